// File: rtl/operand_arbiter_if.sv
// Handshake bundle between three operand requesters, the arbiter and the downstream sink.
// master is the arbiter's view; slave is the surrounding logic's view.
interface operand_arbiter_if #(
  parameter int WIDTH = 32
);
  logic [2:0]       req_valid;
  logic [WIDTH-1:0] req_data0;
  logic [WIDTH-1:0] req_data1;
  logic [WIDTH-1:0] req_data2;
  logic [2:0]       req_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_src;
  logic             out_ready;
  logic [1:0]       sel;
  logic             busy;

  modport master (
    input  req_valid, req_data0, req_data1, req_data2, out_ready,
    output req_ready, out_valid, out_data, out_src, sel, busy
  );

  modport slave (
    output req_valid, req_data0, req_data1, req_data2, out_ready,
    input  req_ready, out_valid, out_data, out_src, sel, busy
  );
endinterface

// File: rtl/operand_arbiter.sv
// Round-robin arbiter for three operand streams feeding one registered output beat.
// A grant lasts up to MAX_BURST beats or until the owner drops valid.
module operand_arbiter #(
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 4
) (
  input logic                clk,
  input logic                rst_n,
  operand_arbiter_if.master  bus
);
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

  state_t           state_reg, state_next;
  logic [1:0]       sel_reg, sel_next;
  logic [1:0]       ptr_reg, ptr_next;
  logic [3:0]       burst_cnt_reg, burst_cnt_next;
  logic             out_valid_reg, out_valid_next;
  logic [WIDTH-1:0] out_data_reg, out_data_next;
  logic [1:0]       out_src_reg, out_src_next;

  logic             can_load;
  logic             xfer;
  logic             sel_valid;
  logic [WIDTH-1:0] sel_data;
  logic [1:0]       winner;
  logic [1:0]       cand;
  logic [1:0]       ptr_after_sel;
  logic [2:0]       ready_vec;

  function automatic logic [1:0] rot3(input logic [1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= 3) s = s - 3;
    return 2'(s);
  endfunction

  assign can_load      = !out_valid_reg || bus.out_ready;
  assign xfer          = (state_reg == GRANT) && sel_valid && can_load;
  assign ptr_after_sel = (sel_reg == 2'd2) ? 2'd0 : sel_reg + 2'd1;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_ready
      assign ready_vec[gi] = (state_reg == GRANT) && (sel_reg == 2'(gi)) && can_load;
    end
  endgenerate

  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    case (sel_reg)
      2'd0:    begin sel_valid = bus.req_valid[0]; sel_data = bus.req_data0; end
      2'd1:    begin sel_valid = bus.req_valid[1]; sel_data = bus.req_data1; end
      2'd2:    begin sel_valid = bus.req_valid[2]; sel_data = bus.req_data2; end
      default: begin sel_valid = 1'b0; sel_data = '0; end
    endcase
  end

  // Scan from the farthest candidate back to ptr so the nearest valid one wins.
  always_comb begin
    winner = ptr_reg;
    cand   = ptr_reg;
    for (int k = 2; k >= 0; k--) begin
      cand = rot3(ptr_reg, k);
      if (bus.req_valid[cand]) winner = cand;
    end
  end

  always_comb begin
    state_next     = state_reg;
    sel_next       = sel_reg;
    ptr_next       = ptr_reg;
    burst_cnt_next = burst_cnt_reg;
    out_valid_next = out_valid_reg;
    out_data_next  = out_data_reg;
    out_src_next   = out_src_reg;
    case (state_reg)
      IDLE: begin
        if (|bus.req_valid) begin
          state_next     = GRANT;
          sel_next       = winner;
          burst_cnt_next = '0;
        end
      end
      GRANT: begin
        if (xfer) begin
          burst_cnt_next = burst_cnt_reg + 4'd1;
          if (burst_cnt_reg == LAST_BEAT) begin
            state_next = IDLE;
            ptr_next   = ptr_after_sel;
          end
        end else if (!sel_valid) begin
          state_next = IDLE;
          ptr_next   = ptr_after_sel;
        end
      end
      default: state_next = IDLE;
    endcase
    // A load in the same cycle as a drain keeps the beat register full.
    if (xfer) begin
      out_valid_next = 1'b1;
      out_data_next  = sel_data;
      out_src_next   = sel_reg;
    end else if (bus.out_ready) begin
      out_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      sel_reg       <= '0;
      ptr_reg       <= '0;
      burst_cnt_reg <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_src_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      sel_reg       <= sel_next;
      ptr_reg       <= ptr_next;
      burst_cnt_reg <= burst_cnt_next;
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
      out_src_reg   <= out_src_next;
    end
  end

  assign bus.req_ready = ready_vec;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.out_src   = out_src_reg;
  assign bus.sel       = sel_reg;
  assign bus.busy      = (state_reg == GRANT);
endmodule

// File: tb/tb_operand_arbiter.sv
// Drives two arbiters (MAX_BURST 4 and 1) with shared stimulus and checks each
// cycle against a behavioural grant/beat model, plus directed sequence checks.
module tb_operand_arbiter;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [2:0]   v;
  logic [W-1:0] d [3];
  logic         ordy;

  operand_arbiter_if #(.WIDTH(W)) if4 ();
  operand_arbiter_if #(.WIDTH(W)) if1 ();

  assign if4.req_valid = v;
  assign if4.req_data0 = d[0];
  assign if4.req_data1 = d[1];
  assign if4.req_data2 = d[2];
  assign if4.out_ready = ordy;
  assign if1.req_valid = v;
  assign if1.req_data0 = d[0];
  assign if1.req_data1 = d[1];
  assign if1.req_data2 = d[2];
  assign if1.out_ready = ordy;

  operand_arbiter #(.WIDTH(W), .MAX_BURST(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.master));
  operand_arbiter #(.WIDTH(W), .MAX_BURST(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.master));

  int n_tests = 0;
  int n_fail  = 0;

  // Model: who owns the grant, beats taken, next priority, and the held beat.
  int           mb [2] = '{4, 1};
  int           m_gnt [2];
  int           m_sel [2];
  int           m_ptr [2];
  int           m_cnt [2];
  int           m_ov  [2];
  int           m_src [2];
  logic [W-1:0] m_od  [2];
  bit           acc4;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_gnt[k] = 0; m_sel[k] = 0; m_ptr[k] = 0; m_cnt[k] = 0;
      m_ov[k] = 0; m_src[k] = 0; m_od[k] = '0;
    end
    acc4 = 1'b0;
  endtask

  function automatic logic [2:0] m_ready(input int k);
    if (m_gnt[k] != 0 && (m_ov[k] == 0 || ordy)) return 3'(1 << m_sel[k]);
    return 3'b000;
  endfunction

  task automatic model_step(input int k);
    bit can, take, rel, found;
    int c;
    can = (m_ov[k] == 0) || ordy;
    take = 1'b0; rel = 1'b0; found = 1'b0;
    if (m_gnt[k] == 0) begin
      for (int j = 0; j < 3; j++) begin
        c = (m_ptr[k] + j) % 3;
        if (!found && v[c]) begin
          found = 1'b1;
          m_sel[k] = c;
        end
      end
      if (found) begin
        m_gnt[k] = 1;
        m_cnt[k] = 0;
      end
    end else begin
      take = v[m_sel[k]] && can;
      if (take) begin
        m_cnt[k]++;
        rel = (m_cnt[k] == mb[k]);
      end else begin
        rel = !v[m_sel[k]];
      end
    end
    if (take) begin
      m_od[k] = d[m_sel[k]];
      m_src[k] = m_sel[k];
      m_ov[k] = 1;
    end else if (ordy) begin
      m_ov[k] = 0;
    end
    if (rel) begin
      m_gnt[k] = 0;
      m_ptr[k] = (m_sel[k] + 1) % 3;
    end
    if (k == 0) acc4 = take;
  endtask

  task automatic chk_outs(input string nm, input int k, input logic ov, input logic [W-1:0] od,
                          input logic [1:0] os, input logic [1:0] sl, input logic bz);
    chk({nm, " out_valid"}, W'(ov), W'(m_ov[k]));
    chk({nm, " out_data"},  od,     m_od[k]);
    chk({nm, " out_src"},   W'(os), W'(m_src[k]));
    chk({nm, " sel"},       W'(sl), W'(m_sel[k]));
    chk({nm, " busy"},      W'(bz), W'(m_gnt[k]));
  endtask

  // One clock: check combinational ready, advance model, check registered outputs.
  task automatic tick();
    #1;
    chk("d4 req_ready", W'(if4.req_ready), W'(m_ready(0)));
    chk("d1 req_ready", W'(if1.req_ready), W'(m_ready(1)));
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    chk_outs("d4", 0, if4.out_valid, if4.out_data, if4.out_src, if4.sel, if4.busy);
    chk_outs("d1", 1, if1.out_valid, if1.out_data, if1.out_src, if1.sel, if1.busy);
  endtask

  initial begin
    logic [1:0]   srcs [$];
    logic [W-1:0] beats [$];
    logic [W-1:0] val;
    int           acc_n;
    int           hold;

    rst_n = 1'b0; v = 3'b000; ordy = 1'b1;
    d[0] = '0; d[1] = '0; d[2] = '0;
    model_reset();
    #12;
    chk("reset d4 req_ready", W'(if4.req_ready), '0);
    chk("reset d1 req_ready", W'(if1.req_ready), '0);
    chk_outs("reset d4", 0, if4.out_valid, if4.out_data, if4.out_src, if4.sel, if4.busy);
    chk_outs("reset d1", 1, if1.out_valid, if1.out_data, if1.out_src, if1.sel, if1.busy);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Fairness: all requesters valid, single-beat grants rotate 0,1,2,...
    v = 3'b111; ordy = 1'b1;
    d[0] = $urandom; d[1] = $urandom; d[2] = $urandom;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (if1.out_valid) srcs.push_back(if1.out_src);
    end
    chk("fair beat count ok", W'(srcs.size() >= 6), W'(1));
    for (int i = 0; i < 6; i++)
      if (i < srcs.size()) chk($sformatf("fair src[%0d]", i), W'(srcs[i]), W'(i % 3));
    v = 3'b000;
    repeat (3) tick();

    // Burst cap: requester 1 streams 0x11..0x16.
    v = 3'b010; val = 32'h11; d[1] = val;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (if4.out_valid) beats.push_back(if4.out_data);
      if (if4.busy) chk("burst sel", W'(if4.sel), W'(1));
      if (acc4) begin
        val = val + 1; d[1] = val;
        if (val == 32'h17) v = 3'b000;
      end
    end
    chk("burst beat count", W'(beats.size()), W'(6));
    for (int i = 0; i < 6; i++)
      if (i < beats.size()) chk($sformatf("burst beat[%0d]", i), beats[i], W'(32'h11 + i));
    repeat (2) tick();

    // Backpressure mid-burst for three cycles.
    v = 3'b010; val = 32'h21; d[1] = val; acc_n = 0; hold = 0;
    for (int i = 0; i < 14; i++) begin
      ordy = (acc_n == 2 && hold < 3) ? 1'b0 : 1'b1;
      tick();
      if (!ordy) begin
        hold++;
        chk("bp hold data", if4.out_data, W'(32'h22));
        chk("bp hold ready", W'(if4.req_ready), '0);
      end
      if (acc4) begin
        acc_n++; val = val + 1; d[1] = val;
        if (acc_n == 4) v = 3'b000;
      end
    end
    ordy = 1'b1;
    chk("bp total beats", W'(acc_n), W'(4));
    repeat (2) tick();

    // Early release: requester 2 drops after 2 beats, requester 0 takes over.
    v = 3'b101; d[2] = 32'h31; d[0] = 32'h40; acc_n = 0;
    tick();
    chk("early first sel", W'(if4.sel), W'(2));
    for (int i = 0; i < 7; i++) begin
      tick();
      if (acc4 && v[2]) begin
        acc_n++; d[2] = d[2] + 1;
        if (acc_n == 2) v = 3'b001;
      end
    end
    chk("early next sel", W'(if4.sel), W'(0));
    chk("early next src", W'(if4.out_src), W'(0));

    // Async reset between edges while granted with a pending beat.
    v = 3'b000;
    repeat (3) tick();
    v = 3'b111;
    repeat (2) tick();
    chk("pre-reset busy", W'(if4.busy), W'(1));
    chk("pre-reset out_valid", W'(if4.out_valid), W'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("async out_valid", W'(if4.out_valid), '0);
    chk("async busy", W'(if4.busy), '0);
    chk("async sel", W'(if4.sel), '0);
    chk("async req_ready", W'(if4.req_ready), '0);
    chk("async out_data", if4.out_data, '0);
    chk("async d1 out_valid", W'(if1.out_valid), '0);
    #2 rst_n = 1'b1;
    model_reset();
    tick();
    chk("post-reset sel", W'(if4.sel), W'(0));
    repeat (3) tick();

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      v = 3'($urandom_range(0, 7));
      d[0] = $urandom; d[1] = $urandom; d[2] = $urandom;
      ordy = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/operand_arbiter.md
OPERAND_ARBITER -- requirements
Module: operand_arbiter

Interface
REQ-001 Parameter: WIDTH, default 32, data width of every requester and output data bus.
REQ-002 Parameter: MAX_BURST, default 4, maximum beats transferred per grant (legal range 1..15).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: req_valid  input  3  per-requester valid; bit i belongs to requester i.
REQ-006 Port: req_data0, req_data1, req_data2  input  WIDTH each  per-requester data.
REQ-007 Port: req_ready  output  3  per-requester accept; combinational.
REQ-008 Port: out_valid  output  1  registered output beat valid.
REQ-009 Port: out_data  output  WIDTH  registered output beat.
REQ-010 Port: out_src  output  2  index of the requester that produced the current out_data.
REQ-011 Port: out_ready  input  1  downstream accept.
REQ-012 Port: sel  output  2  registered select code of the current or last grant (00/01/10; 11 never driven).
REQ-013 Port: busy  output  1  high while in GRANT.

Function
REQ-014 FSM states IDLE and GRANT; no other states.
REQ-015 can_load = !out_valid || out_ready; output register loads only when can_load.
REQ-016 IDLE: if any req_valid bit is set, the winner is chosen round-robin starting at ptr, then ptr+1, then ptr+2 (mod 3); next cycle the FSM is in GRANT with sel=winner and burst_cnt=0; no transfer in the IDLE cycle.
REQ-017 IDLE with req_valid=000: stay IDLE; sel and ptr hold.
REQ-018 req_ready[i] = (state==GRANT) && (sel==i) && can_load; the other bits are 0.
REQ-019 Transfer when req_valid[sel] && req_ready[sel]: out_data <= req_data[sel], out_src <= sel, out_valid <= 1, burst_cnt increments.
REQ-020 out_valid clears when out_ready=1 and no transfer occurs in that cycle; simultaneous drain and load keeps out_valid=1 with new data.
REQ-021 Release: a transfer bringing burst_cnt to MAX_BURST, or req_valid[sel]=0 in any GRANT cycle, puts the FSM in IDLE next cycle with ptr <= (sel+1) mod 3.
REQ-022 Backpressure: while out_valid=1 and out_ready=0, no transfer occurs, burst_cnt and grant hold, and out_data/out_src remain stable.
REQ-023 Throughput: one beat per cycle within a burst when out_ready stays 1; re-arbitration costs exactly one IDLE cycle.
REQ-024 Latency: req_valid asserted in IDLE at cycle n gives req_ready at n+1 (if can_load) and out_valid at n+2.
REQ-025 Requesters that deassert req_valid before acceptance lose no data held by the block; the arbiter never stores unaccepted beats.
REQ-026 busy = (state==GRANT).

Reset
REQ-027 rst_n low immediately forces state=IDLE, sel=00, ptr=00, burst_cnt=0, out_valid=0, out_src=00, out_data=0, req_ready=000, busy=0, regardless of clock.
REQ-028 Reset mid-burst or with out_valid=1 discards the pending beat; the first arbitration after release starts at requester 0.
REQ-029 Reset release is synchronous to clk by the surrounding design; the block samples no inputs while rst_n=0.

Verification
REQ-030 Fairness: all three requesters hold valid, out_ready=1, MAX_BURST=1 -> out_src sequence 0,1,2,0,1,2 with one idle cycle between beats.
REQ-031 Burst cap: requester 1 alone streams 0x11..0x16, MAX_BURST=4 -> out_data 0x11..0x14, one gap, then 0x15,0x16; sel=01 throughout.
REQ-032 Backpressure: out_ready held 0 for 3 cycles mid-burst -> out_data stable, req_ready=000, burst_cnt unchanged; resume without loss or duplication.
REQ-033 Early release: requester 2 drops valid after 2 of 4 beats -> FSM goes to IDLE, ptr=00, requester 0 wins next if valid.
REQ-034 Async reset: rst_n pulsed low between clock edges during GRANT with out_valid=1 -> out_valid=0, busy=0, sel=00 before the next edge.
REQ-035 Simultaneous drain/load: out_valid=1, out_ready=1, transfer pending -> out_valid stays 1 and out_data updates in the same edge.
